fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
Pointer and flag controller that sequences the team's memory block (DATA_SIZE wide, DEPTH entries) as a synchronous FIFO for one PCIe switch lane.
- Accepts push/pop requests from the upstream and downstream lane logic.
- Drives the memory's write, read, wr_ptr and rd_ptr.
- Produces full/empty, programmable almost-full/almost-empty and a sticky error.
- almost_full doubles as the lane pause (backpressure) signal.

Parameters:
DATA_SIZE, 10, width of a FIFO word (passed through to the memory instance)
DEPTH, 8, number of memory entries; power of two
PTR_SIZE, 3, log2(DEPTH); pointer width
CNT_SIZE, 4, PTR_SIZE+1; occupancy counter width
UMBRAL_HI_RST, 6, almost-full threshold loaded at reset
UMBRAL_LO_RST, 1, almost-empty threshold loaded at reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
init  in  1  latch thresholds and leave INIT
umbral_hi  in  CNT_SIZE  almost-full threshold, sampled on init
umbral_lo  in  CNT_SIZE  almost-empty threshold, sampled on init
push  in  1  write request; data is presented to the memory directly by the requester
pop  in  1  read request
write  out  1  memory write enable
read  out  1  memory read enable
wr_ptr  out  PTR_SIZE  memory write address
rd_ptr  out  PTR_SIZE  memory read address
count  out  CNT_SIZE  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= umbral_hi register; used as pause
almost_empty  out  1  count <= umbral_lo register
data_valid  out  1  memory data_out carries a popped word this cycle
error  out  1  sticky overflow/underflow flag
state  out  2  FSM state, for debug

Behaviour:
- Reset (reset==0 at posedge clk) sets:
  - wr_ptr=0, rd_ptr=0, count=0, error=0, state=INIT.
  - Threshold registers = UMBRAL_HI_RST / UMBRAL_LO_RST.
- Reset flag values: empty=1, full=0, almost_full=0, almost_empty=1.
- write, read and data_valid are 0 whenever reset is asserted or state is INIT or ERROR.
- Reset mid-operation discards all contents. The memory's own reset clears its array in the same cycle.
- FSM states: INIT=0, IDLE=1, ACTIVE=2, ERROR=3.
  - INIT: push/pop ignored (no error). When init=1, latch umbral_hi/umbral_lo and go to IDLE next cycle.
  - IDLE: count==0. An accepted push moves to ACTIVE.
  - ACTIVE: count>0. Return to IDLE when the next count is 0.
  - ERROR: entered on overflow or underflow. Sticky: all requests are blocked until reset.
- Acceptance, evaluated combinationally from registered count each cycle:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - write = push_ok; read = pop_ok.
  - data_valid = read. The memory returns mem[rd_ptr] combinationally, so read latency is 0 cycles.
- Overflow: push & full & ~pop. The write is suppressed and error=1 plus state=ERROR on the next edge.
- Underflow: pop & empty. The read is suppressed and error=1 plus state=ERROR, even if push=1 in the same cycle; that push is also dropped.
- Simultaneous push & pop:
  - On full: both are accepted, both pointers advance, count is unchanged.
  - In the normal (non-full, non-empty) case: both are accepted and count is unchanged.
- Pointer update on each accepted operation: ptr <= ptr+1, modulo DEPTH. Wrap 7->0 is natural truncation.
- Count update: count <= count + push_ok - pop_ok. Count range is 0..DEPTH.
- Flags are pure decodes of the count and threshold registers, so they update one cycle after the accepting edge.
- The almost_full/almost_empty compares are unsigned CNT_SIZE-wide.
  - umbral_hi=0 forces almost_full=1.
  - umbral_lo>=DEPTH forces almost_empty=1.
- Thresholds cannot change outside INIT.

Decomposition:
- Shared include file holds:
  - The FSM state encodings (INIT/IDLE/ACTIVE/ERROR).
  - Default DEPTH, PTR_SIZE and threshold constants, reused by the lane arbiter.
- One natural sub-module: the existing memory block.
  - Instantiate it as the storage behind fifo_ctrl inside a wrapper, fifo_lane.
  - fifo_lane connects write, read, wr_ptr and rd_ptr.
  - fifo_ctrl itself contains no storage.

Test Plan:
- Reset, then init with umbral_hi=6, umbral_lo=1 -> state IDLE, empty=1, almost_empty=1, count=0, error=0.
- 8 consecutive pushes -> count 1..8; almost_full rises when count reaches 6; full=1 after the 8th push; wr_ptr wraps to 0.
- Push while full, no pop -> write=0, error=1, state ERROR next cycle; subsequent push/pop are ignored until reset.
- Fill with 3 entries, then push+pop together for 10 cycles -> count stays 3, both pointers wrap, data_valid=1 every cycle, popped data in order.
- Pop on empty with push=1 -> read=0, write=0, error=1, count stays 0.
- Reset asserted while ACTIVE with count=5 -> next cycle count=0, pointers 0, empty=1, state INIT; push before init -> write=0, no error.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared FIFO state encodings and default sizing constants
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_PTR_SIZE  = 3;
  localparam int FIFO_CNT_SIZE  = 4;
  localparam int FIFO_UMBRAL_HI = 6;
  localparam int FIFO_UMBRAL_LO = 1;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } fifo_state_t;

endpackage

// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - one switch-lane FIFO: controller plus its memory block
module fifo_lane
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_SIZE     = 10,
  parameter int DEPTH         = FIFO_DEPTH,
  parameter int PTR_SIZE      = FIFO_PTR_SIZE,
  parameter int CNT_SIZE      = FIFO_CNT_SIZE,
  parameter int UMBRAL_HI_RST = FIFO_UMBRAL_HI,
  parameter int UMBRAL_LO_RST = FIFO_UMBRAL_LO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CNT_SIZE-1:0]  umbral_hi,
  input  logic [CNT_SIZE-1:0]  umbral_lo,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [CNT_SIZE-1:0]  count,
  output logic                 full,
  output logic                 empty,
  output logic                 pause,
  output logic                 almost_empty,
  output logic                 error,
  output logic [1:0]           state
);

  logic                write, read;
  logic [PTR_SIZE-1:0] wr_ptr, rd_ptr;

  fifo_ctrl #(
    .DEPTH         (DEPTH),
    .PTR_SIZE      (PTR_SIZE),
    .CNT_SIZE      (CNT_SIZE),
    .UMBRAL_HI_RST (UMBRAL_HI_RST),
    .UMBRAL_LO_RST (UMBRAL_LO_RST)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_hi    (umbral_hi),
    .umbral_lo    (umbral_lo),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (pause),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .error        (error),
    .state        (state)
  );

  fifo_mem #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .PTR_SIZE  (PTR_SIZE)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .read     (read),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .data_in  (data_in),
    .data_out (data_out)
  );

endmodule

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - lane storage array with synchronous write and combinational read
module fifo_mem #(
  parameter int DATA_SIZE = 10,
  parameter int DEPTH     = 8,
  parameter int PTR_SIZE  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [PTR_SIZE-1:0]  wr_ptr,
  input  logic [PTR_SIZE-1:0]  rd_ptr,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Reset wipes the array; otherwise store the word at wr_ptr on an accepted write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Zero-latency read: the popped word is on data_out in the same cycle as read.
  always_comb begin
    data_out = '0;
    if (read) begin
      data_out = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer, occupancy, flag and error sequencer
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH         = FIFO_DEPTH,
  parameter int PTR_SIZE      = FIFO_PTR_SIZE,
  parameter int CNT_SIZE      = FIFO_CNT_SIZE,
  parameter int UMBRAL_HI_RST = FIFO_UMBRAL_HI,
  parameter int UMBRAL_LO_RST = FIFO_UMBRAL_LO
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [CNT_SIZE-1:0] umbral_hi,
  input  logic [CNT_SIZE-1:0] umbral_lo,
  input  logic                push,
  input  logic                pop,
  output logic                write,
  output logic                read,
  output logic [PTR_SIZE-1:0] wr_ptr,
  output logic [PTR_SIZE-1:0] rd_ptr,
  output logic [CNT_SIZE-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                data_valid,
  output logic                error,
  output logic [1:0]          state
);

  fifo_state_t         state_q, state_d;
  logic [CNT_SIZE-1:0] count_q, count_d;
  logic [CNT_SIZE-1:0] umbral_hi_q, umbral_lo_q;
  logic [PTR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic                error_q;
  logic                running, underflow, overflow, pop_ok, push_ok;

  assign full         = (count_q == CNT_SIZE'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= umbral_hi_q);
  assign almost_empty = (count_q <= umbral_lo_q);

  // Request acceptance from the registered count; an underflow also drops a same-cycle push.
  always_comb begin
    running   = reset && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    underflow = running & pop & empty;
    overflow  = running & push & full & ~pop;
    pop_ok    = running & pop & ~empty;
    push_ok   = running & push & ~underflow & (~full | pop_ok);
    count_d   = count_q + CNT_SIZE'(push_ok) - CNT_SIZE'(pop_ok);
  end

  // Next-state selection: INIT waits for init, errors are sticky, IDLE/ACTIVE track occupancy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE, ST_ACTIVE: begin
        if (underflow || overflow) begin
          state_d = ST_ERROR;
        end else if (count_d == '0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointers, occupancy, thresholds and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      umbral_hi_q <= CNT_SIZE'(UMBRAL_HI_RST);
      umbral_lo_q <= CNT_SIZE'(UMBRAL_LO_RST);
    end else begin
      if ((state_q == ST_INIT) && init) begin
        umbral_hi_q <= umbral_hi;
        umbral_lo_q <= umbral_lo;
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      error_q <= error_q | underflow | overflow;
    end
  end

  assign write      = push_ok;
  assign read       = pop_ok;
  assign data_valid = pop_ok;
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign count      = count_q;
  assign error      = error_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl against a queue-based model
module tb_fifo_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       init = 1'b0;
  logic [3:0] umbral_hi = 4'd0;
  logic [3:0] umbral_lo = 4'd0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       write, read, full, empty, almost_full, almost_empty, data_valid, error;
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of slot addresses holding stored entries, in arrival order.
  int q[$];
  int m_wr = 0;
  int m_rd = 0;
  int m_st = 0;
  int m_hi = 6;
  int m_lo = 1;
  int m_err = 0;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_hi    (umbral_hi),
    .umbral_lo    (umbral_lo),
    .push         (push),
    .pop          (pop),
    .write        (write),
    .read         (read),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .error        (error),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic o, input logic in_init, input logic rst_n,
                     input logic [3:0] h, input logic [3:0] l);
    int  n;
    int  junk;
    bit  run, under, over, exp_r, exp_w;
    @(negedge clk);
    push = p; pop = o; init = in_init; reset = rst_n; umbral_hi = h; umbral_lo = l;
    #1;
    n     = q.size();
    run   = rst_n && (m_st == 1 || m_st == 2);
    under = run && o && (n == 0);
    over  = run && p && (n == DEPTH) && !o;
    exp_r = run && o && (n > 0);
    exp_w = run && p && !under && ((n < DEPTH) || exp_r);
    check("write", write, exp_w);
    check("read", read, exp_r);
    check("data_valid", data_valid, exp_r);
    if (exp_r) check("rd_ptr_order", rd_ptr, q[0]);
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_wr = 0; m_rd = 0; m_st = 0; m_hi = 6; m_lo = 1; m_err = 0;
    end else if (m_st == 0) begin
      if (in_init) begin m_hi = h; m_lo = l; m_st = 1; end
    end else if (m_st == 1 || m_st == 2) begin
      if (under || over) begin
        m_err = 1; m_st = 3;
      end else begin
        if (exp_r) begin junk = q.pop_front(); m_rd = (m_rd + 1) % DEPTH; end
        if (exp_w) begin q.push_back(m_wr); m_wr = (m_wr + 1) % DEPTH; end
        m_st = (q.size() == 0) ? 1 : 2;
      end
    end
    #1;
    check("count", count, q.size());
    check("wr_ptr", wr_ptr, m_wr);
    check("rd_ptr", rd_ptr, m_rd);
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("almost_full", almost_full, q.size() >= m_hi);
    check("almost_empty", almost_empty, q.size() <= m_lo);
    check("error", error, m_err);
    check("state", state, m_st);
  endtask

  task automatic op(input logic p, input logic o);
    cyc(p, o, 1'b0, 1'b1, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_init(input logic [3:0] h, input logic [3:0] l);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, h, l);
  endtask

  initial begin
    logic p, o;
    // Reset state, then init 6/1.
    do_reset();
    do_reset();
    do_init(4'd6, 4'd1);
    // Fill to full, wrap wr_ptr, then overflow and confirm requests stay blocked.
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0);
    op(1'b1, 1'b0);
    op(1'b1, 1'b1);
    op(1'b0, 1'b1);
    // Steady push+pop at occupancy 3 across pointer wrap.
    do_reset();
    do_init(4'd6, 4'd1);
    for (int i = 0; i < 3; i++) op(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) op(1'b1, 1'b1);
    // Push+pop on a full FIFO keeps it full.
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0);
    op(1'b1, 1'b1);
    op(1'b1, 1'b1);
    // Drain, then underflow with a same-cycle push.
    for (int i = 0; i < 8; i++) op(1'b0, 1'b1);
    op(1'b1, 1'b1);
    // Reset mid-operation at count 5, then push before init is ignored.
    do_reset();
    do_init(4'd6, 4'd1);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0);
    do_reset();
    op(1'b1, 1'b0);
    op(1'b0, 1'b1);
    // Threshold edge cases: hi=0 forces almost_full, lo>=DEPTH forces almost_empty.
    do_init(4'd0, 4'd9);
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0);
    // Randomized traffic with random thresholds and occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_st == 0) begin
        cyc(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 50), 1'b1, 1'b1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end else if (m_st == 3 || $urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 3) == 0) op(1'b1, 1'b1);
        else do_reset();
      end else begin
        p = ($urandom_range(0, 99) < 55);
        o = ($urandom_range(0, 99) < 45);
        op(p, o);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
